// File: rtl/pump_ctrl_pkg.sv
// Shared types and elaboration helpers for the peristaltic pump controller.
// Holds the controller state encoding, the all-valves-closed mask and the phase width.
package pump_ctrl_pkg;

  localparam int MAX_VALVES = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int phase_w(input int n_valves);
    return $clog2(2 * n_valves);
  endfunction

  // Safe-state mask: one pressurised bit per valve, upper bits zero.
  function automatic logic [MAX_VALVES-1:0] all_closed(input int n_valves);
    logic [MAX_VALVES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_VALVES; i++) begin
      if (i < n_valves) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pump_pattern_gen.sv
// Combinational map from (phase, direction) to the per-valve closed mask.
// Even phase 2i opens valve i alone; odd phase 2i+1 opens valves i and i+1 (mod N).
module pump_pattern_gen
  import pump_ctrl_pkg::*;
#(
  parameter  int N_VALVES = 3,
  localparam int PHASE_W  = phase_w(N_VALVES)
) (
  input  logic [PHASE_W-1:0]  phase_i,
  input  logic                dir_i,
  output logic [N_VALVES-1:0] closed_o
);

  logic [N_VALVES-1:0] open_fwd;
  int                  lead;
  int                  trail;

  always_comb begin
    lead     = 32'(phase_i >> 1);
    trail    = (lead == N_VALVES - 1) ? 0 : lead + 1;
    open_fwd = '0;
    closed_o = '0;
    for (int j = 0; j < N_VALVES; j++) begin
      if (j == lead || (phase_i[0] && j == trail)) open_fwd[j] = 1'b1;
    end
    // Reverse direction mirrors valve indices rather than reversing phase order.
    for (int j = 0; j < N_VALVES; j++) begin
      closed_o[j] = dir_i ? ~open_fwd[N_VALVES-1-j] : ~open_fwd[j];
    end
  end

endmodule

// File: rtl/peristaltic_pump_ctrl.sv
// Travelling-wave valve sequencer with programmable dwell, direction and stroke count.
// All outputs registered: a start accepted at edge k shows pattern(0) from cycle k+1.
module peristaltic_pump_ctrl
  import pump_ctrl_pkg::*;
#(
  parameter  int N_VALVES = 3,
  parameter  int DWELL_W  = 16,
  parameter  int STROKE_W = 16,
  localparam int PHASE_W  = phase_w(N_VALVES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dir,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [STROKE_W-1:0] strokes,
  input  logic                pause,
  input  logic                abort,
  output logic [N_VALVES-1:0] valve_air,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [STROKE_W-1:0] stroke_cnt,
  output logic [PHASE_W-1:0]  phase
);

  if (N_VALVES < 3 || N_VALVES > MAX_VALVES) begin : g_bad_n_valves
    $error("peristaltic_pump_ctrl: N_VALVES must be in 3..16");
  end

  localparam logic [N_VALVES-1:0] ALL_CLOSED = N_VALVES'(all_closed(N_VALVES));
  localparam logic [PHASE_W-1:0]  LAST_PHASE = PHASE_W'(2 * N_VALVES - 1);

  state_e              state_q,      state_d;
  logic [PHASE_W-1:0]  phase_q,      phase_d;
  logic [DWELL_W-1:0]  dwell_cnt_q,  dwell_cnt_d;
  logic [DWELL_W-1:0]  dwell_lat_q,  dwell_lat_d;
  logic [STROKE_W-1:0] stroke_cnt_q, stroke_cnt_d;
  logic [STROKE_W-1:0] strokes_lat_q, strokes_lat_d;
  logic                dir_lat_q,    dir_lat_d;
  logic [N_VALVES-1:0] air_q,        air_d;
  logic                busy_q,       busy_d;
  logic                done_q,       done_d;
  logic                aborted_q,    aborted_d;
  logic [N_VALVES-1:0] pattern_mask;

  // Fed from next-state values so the registered air lines line up with phase.
  pump_pattern_gen #(.N_VALVES(N_VALVES)) u_pattern (
    .phase_i  (phase_d),
    .dir_i    (dir_lat_d),
    .closed_o (pattern_mask)
  );

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    dwell_cnt_d   = dwell_cnt_q;
    dwell_lat_d   = dwell_lat_q;
    stroke_cnt_d  = stroke_cnt_q;
    strokes_lat_d = strokes_lat_q;
    dir_lat_d     = dir_lat_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d       = RUN;
          phase_d       = '0;
          dwell_cnt_d   = '0;
          stroke_cnt_d  = '0;
          dwell_lat_d   = dwell;
          strokes_lat_d = strokes;
          dir_lat_d     = dir;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (!pause) begin
          if (dwell_cnt_q == dwell_lat_q) begin
            dwell_cnt_d = '0;
            if (phase_q == LAST_PHASE) begin
              phase_d      = '0;
              stroke_cnt_d = stroke_cnt_q + STROKE_W'(1);
              if (strokes_lat_q != '0 && stroke_cnt_d == strokes_lat_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              phase_d = phase_q + PHASE_W'(1);
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    air_d  = busy_d ? pattern_mask : ALL_CLOSED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      dwell_cnt_q   <= '0;
      dwell_lat_q   <= '0;
      stroke_cnt_q  <= '0;
      strokes_lat_q <= '0;
      dir_lat_q     <= 1'b0;
      air_q         <= ALL_CLOSED;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      dwell_cnt_q   <= dwell_cnt_d;
      dwell_lat_q   <= dwell_lat_d;
      stroke_cnt_q  <= stroke_cnt_d;
      strokes_lat_q <= strokes_lat_d;
      dir_lat_q     <= dir_lat_d;
      air_q         <= air_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
    end
  end

  assign valve_air  = air_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign stroke_cnt = stroke_cnt_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_peristaltic_pump_ctrl.sv
// Scoreboard bench: stimulus pushes cycle-tagged expectations, a negedge monitor pops and compares.
// Three instances cover N=3, N=8 and a 4-bit stroke counter.
module tb_peristaltic_pump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1, start2, dir, pause, abort;
  logic [15:0] dwell, strokes;

  logic [2:0]  air0;  logic busy0, done0, ab0; logic [15:0] scnt0; logic [2:0] ph0;
  logic [7:0]  air1;  logic busy1, done1, ab1; logic [15:0] scnt1; logic [3:0] ph1;
  logic [2:0]  air2;  logic busy2, done2, ab2; logic [3:0]  scnt2; logic [2:0] ph2;

  peristaltic_pump_ctrl #(.N_VALVES(3), .DWELL_W(16), .STROKE_W(16)) u0 (
    .clk(clk), .rst(rst), .start(start0), .dir(dir), .dwell(dwell), .strokes(strokes),
    .pause(pause), .abort(abort), .valve_air(air0), .busy(busy0), .done(done0),
    .aborted(ab0), .stroke_cnt(scnt0), .phase(ph0));

  peristaltic_pump_ctrl #(.N_VALVES(8), .DWELL_W(16), .STROKE_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dir(dir), .dwell(dwell), .strokes(strokes),
    .pause(pause), .abort(abort), .valve_air(air1), .busy(busy1), .done(done1),
    .aborted(ab1), .stroke_cnt(scnt1), .phase(ph1));

  peristaltic_pump_ctrl #(.N_VALVES(3), .DWELL_W(16), .STROKE_W(4)) u2 (
    .clk(clk), .rst(rst), .start(start2), .dir(dir), .dwell(dwell), .strokes(strokes[3:0]),
    .pause(pause), .abort(abort), .valve_air(air2), .busy(busy2), .done(done2),
    .aborted(ab2), .stroke_cnt(scnt2), .phase(ph2));

  typedef struct packed {
    int          id;
    int          cyc;
    logic [63:0] tag;
    logic [15:0] air;
    logic        busy;
    logic        done;
    logic        ab;
    logic [15:0] scnt;
    logic        chk_scnt;
    logic [4:0]  ph;
    logic        chk_ph;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [2:0] fwd3 [0:5];
  logic [2:0] rev3 [0:5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int id, input int c, input logic [63:0] tag,
                            input logic [15:0] air, input logic b, input logic d, input logic a,
                            input logic [15:0] sc, input logic chk_sc,
                            input logic [4:0] ph, input logic chk_ph);
    exp_t e;
    e.id = id; e.cyc = c; e.tag = tag; e.air = air; e.busy = b; e.done = d; e.ab = a;
    e.scnt = sc; e.chk_scnt = chk_sc; e.ph = ph; e.chk_ph = chk_ph;
    sb.push_back(e);
  endtask

  exp_t        m;
  logic [15:0] a_air, a_sc;
  logic        a_b, a_d, a_a, bad;
  logic [4:0]  a_ph;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m = sb.pop_front();
      checks++;
      if (m.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", m.tag, m.cyc, cyc);
      end else begin
        case (m.id)
          0: begin a_air = {13'b0, air0}; a_b = busy0; a_d = done0; a_a = ab0;
                   a_sc = scnt0; a_ph = {2'b0, ph0}; end
          1: begin a_air = {8'b0, air1}; a_b = busy1; a_d = done1; a_a = ab1;
                   a_sc = scnt1; a_ph = {1'b0, ph1}; end
          default: begin a_air = {13'b0, air2}; a_b = busy2; a_d = done2; a_a = ab2;
                   a_sc = {12'b0, scnt2}; a_ph = {2'b0, ph2}; end
        endcase
        bad = (a_air !== m.air) || (a_b !== m.busy) || (a_d !== m.done) || (a_a !== m.ab) ||
              (m.chk_scnt && a_sc !== m.scnt) || (m.chk_ph && a_ph !== m.ph);
        if (bad) begin
          errors++;
          $display("FAIL %s dut%0d cyc%0d: got air=%b busy=%b done=%b ab=%b scnt=%0d ph=%0d, want air=%b busy=%b done=%b ab=%b scnt=%0d(%0b) ph=%0d(%0b)",
                   m.tag, m.id, cyc, a_air, a_b, a_d, a_a, a_sc, a_ph,
                   m.air, m.busy, m.done, m.ab, m.scnt, m.chk_scnt, m.ph, m.chk_ph);
        end
      end
    end
  end

  int t0;
  int p;
  logic [15:0] open8;

  initial begin
    fwd3[0] = 3'b110; fwd3[1] = 3'b100; fwd3[2] = 3'b101;
    fwd3[3] = 3'b001; fwd3[4] = 3'b011; fwd3[5] = 3'b010;
    rev3[0] = 3'b011; rev3[1] = 3'b001; rev3[2] = 3'b101;
    rev3[3] = 3'b100; rev3[4] = 3'b110; rev3[5] = 3'b010;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    dir = 1'b0; pause = 1'b0; abort = 1'b0; dwell = '0; strokes = '0;
    tick(); tick();
    rst = 1'b0;
    expect_out(0, cyc + 1, "reset", 16'h0007, 0, 0, 0, 0, 1, 0, 1);
    expect_out(1, cyc + 1, "reset", 16'h00ff, 0, 0, 0, 0, 1, 0, 1);
    expect_out(2, cyc + 1, "reset", 16'h0007, 0, 0, 0, 0, 1, 0, 1);
    tick(); tick();

    // Forward run, dwell 1, two strokes.
    dir = 1'b0; dwell = 16'd1; strokes = 16'd2; start0 = 1'b1; t0 = cyc;
    for (int c = 1; c <= 24; c++) begin
      p = ((c - 1) / 2) % 6;
      expect_out(0, t0 + c, "fwd2", {13'b0, fwd3[p]}, 1, 0, 0, 16'((c - 1) / 12), 1, 5'(p), 1);
    end
    expect_out(0, t0 + 25, "fwd_done", 16'h0007, 0, 1, 0, 16'd2, 1, 0, 1);
    expect_out(0, t0 + 26, "fwd_hold", 16'h0007, 0, 0, 0, 16'd2, 1, 0, 1);
    tick(); start0 = 1'b0;
    repeat (27) tick();

    // Reverse run, dwell 0, one stroke.
    dir = 1'b1; dwell = 16'd0; strokes = 16'd1; start0 = 1'b1; t0 = cyc;
    for (int c = 1; c <= 6; c++)
      expect_out(0, t0 + c, "rev1", {13'b0, rev3[c - 1]}, 1, 0, 0, 0, 1, 5'(c - 1), 1);
    expect_out(0, t0 + 7, "rev_done", 16'h0007, 0, 1, 0, 16'd1, 1, 0, 1);
    tick(); start0 = 1'b0;
    repeat (8) tick();

    // Pause held for cycles 3..7 with dwell 3, then abort at cycle 10.
    dir = 1'b0; dwell = 16'd3; strokes = 16'd1; start0 = 1'b1; t0 = cyc;
    for (int c = 1; c <= 9; c++)
      expect_out(0, t0 + c, "pause", 16'h0006, 1, 0, 0, 0, 1, 0, 1);
    expect_out(0, t0 + 10, "pause_ph1", 16'h0004, 1, 0, 0, 0, 1, 5'd1, 1);
    expect_out(0, t0 + 11, "pause_ab", 16'h0007, 0, 0, 1, 0, 1, 0, 0);
    expect_out(0, t0 + 12, "pause_idl", 16'h0007, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      tick();
      start0 = 1'b0;
      pause  = (k >= 3 && k <= 7);
      abort  = (k == 10);
    end

    // Continuous run; start with new params at cycle 20 is ignored; abort at 40.
    dir = 1'b0; dwell = 16'd1; strokes = 16'd0; start0 = 1'b1; t0 = cyc;
    for (int c = 1; c <= 40; c++) begin
      p = ((c - 1) / 2) % 6;
      expect_out(0, t0 + c, "cont", {13'b0, fwd3[p]}, 1, 0, 0, 16'((c - 1) / 12), 1, 5'(p), 1);
    end
    expect_out(0, t0 + 41, "cont_ab", 16'h0007, 0, 0, 1, 16'd3, 1, 0, 0);
    expect_out(0, t0 + 42, "cont_idl", 16'h0007, 0, 0, 0, 16'd3, 1, 0, 0);
    for (int k = 1; k <= 43; k++) begin
      tick();
      start0 = (k == 20);
      if (k == 20) begin dir = 1'b1; dwell = 16'd5; strokes = 16'd1; end
      abort = (k == 40);
    end

    // Start and abort together in IDLE: start ignored, stroke count untouched.
    dir = 1'b0; dwell = 16'd0; strokes = 16'd1; start0 = 1'b1; abort = 1'b1; t0 = cyc;
    expect_out(0, t0 + 1, "st_ab", 16'h0007, 0, 0, 0, 16'd3, 1, 0, 0);
    expect_out(0, t0 + 2, "st_ab2", 16'h0007, 0, 0, 0, 16'd3, 1, 0, 0);
    tick(); start0 = 1'b0; abort = 1'b0;
    repeat (3) tick();

    // Abort on the final stroke boundary beats done.
    dir = 1'b0; dwell = 16'd0; strokes = 16'd1; start0 = 1'b1; t0 = cyc;
    for (int c = 1; c <= 6; c++)
      expect_out(0, t0 + c, "ab_fin", {13'b0, fwd3[c - 1]}, 1, 0, 0, 0, 1, 5'(c - 1), 1);
    expect_out(0, t0 + 7, "ab_fin_p", 16'h0007, 0, 0, 1, 0, 0, 0, 0);
    expect_out(0, t0 + 8, "ab_fin_i", 16'h0007, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      start0 = 1'b0;
      abort  = (k == 6);
    end

    // Reset mid-run after one stroke has completed.
    dir = 1'b0; dwell = 16'd0; strokes = 16'd0; start0 = 1'b1; t0 = cyc;
    for (int c = 1; c <= 8; c++)
      expect_out(0, t0 + c, "prerst", {13'b0, fwd3[(c - 1) % 6]}, 1, 0, 0,
                 16'((c - 1) / 6), 1, 5'((c - 1) % 6), 1);
    expect_out(0, t0 + 9, "midrst", 16'h0007, 0, 0, 0, 0, 1, 0, 1);
    expect_out(0, t0 + 10, "postrst", 16'h0007, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      start0 = 1'b0;
      rst    = (k == 8);
    end

    // N=8, dwell 0, one stroke: 16 phases.
    dir = 1'b0; dwell = 16'd0; strokes = 16'd1; start1 = 1'b1; t0 = cyc;
    for (int c = 1; c <= 16; c++) begin
      p = c - 1;
      open8 = (16'd1 << (p / 2)) | ((p % 2 == 1) ? (16'd1 << (((p / 2) + 1) % 8)) : 16'd0);
      expect_out(1, t0 + c, "n8", {8'b0, ~open8[7:0]}, 1, 0, 0, 0, 1, 5'(p), 1);
    end
    expect_out(1, t0 + 17, "n8_done", 16'h00ff, 0, 1, 0, 16'd1, 1, 0, 1);
    tick(); start1 = 1'b0;
    repeat (18) tick();

    // 4-bit stroke counter wraps 15 -> 0 in continuous mode with no done.
    dir = 1'b0; dwell = 16'd0; strokes = 16'd0; start2 = 1'b1; t0 = cyc;
    for (int c = 1; c <= 100; c++)
      expect_out(2, t0 + c, "wrap", {13'b0, fwd3[(c - 1) % 6]}, 1, 0, 0,
                 16'(((c - 1) / 6) % 16), 1, 5'((c - 1) % 6), 1);
    expect_out(2, t0 + 101, "wrap_ab", 16'h0007, 0, 0, 1, 16'd0, 1, 0, 0);
    for (int k = 1; k <= 102; k++) begin
      tick();
      start2 = 1'b0;
      abort  = (k == 100);
    end

    repeat (3) tick();
    while (sb.size() > 0) begin
      m = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", m.tag, m.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
